// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch bus: request and word address go out from the fetch
// stage, acknowledge and instruction data come back from memory.
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the program counter, fetches words over a req/ack
// bus and hands {instruction, pc} to decode; control transfers arrive as redirects.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    pc_fetch_if.master  bus,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] req_addr_r;
    logic [31:0] req_addr_nxt_s;
    logic        valid_r;
    logic        valid_nxt_s;
    logic [31:0] instr_r;
    logic [31:0] instr_nxt_s;
    logic [31:0] fpc_r;
    logic [31:0] fpc_nxt_s;
    logic        misalign_r;
    logic        misalign_nxt_s;
    logic        req_s;
    logic [31:0] addr_s;
    logic        capture_s;
    logic        slot_blocked_s;
    logic [31:0] target_s;

    assign slot_blocked_s = valid_r && stall;
    assign target_s       = {redirect_pc[31:2], 2'b00};

    // Next-state, next-register values and fetch-bus drive
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        req_addr_nxt_s = req_addr_r;
        valid_nxt_s    = valid_r;
        instr_nxt_s    = instr_r;
        fpc_nxt_s      = fpc_r;
        misalign_nxt_s = 1'b0;
        req_s          = 1'b0;
        addr_s         = req_addr_r;
        capture_s      = 1'b0;

        case (state_r)
            ST_RUN: begin
                addr_s = pc_r;
                if (!redirect && !slot_blocked_s) begin
                    req_s = 1'b1;
                    if (bus.imem_ack) begin
                        capture_s = 1'b1;
                    end else begin
                        req_addr_nxt_s = pc_r;
                        state_nxt_s    = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                req_s = 1'b1;
                if (bus.imem_ack) begin
                    capture_s   = !redirect;
                    state_nxt_s = ST_RUN;
                end else if (redirect) begin
                    state_nxt_s = ST_KILL;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_KILL: begin
                req_s = 1'b1;
                if (bus.imem_ack) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_KILL;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase

        // Redirect outranks capture and stall; a flush empties the slot even while decode stalls
        if (redirect) begin
            pc_nxt_s       = target_s;
            valid_nxt_s    = 1'b0;
            misalign_nxt_s = (redirect_pc[1:0] != 2'b00);
        end else if (capture_s) begin
            pc_nxt_s    = addr_s + 32'd4;
            valid_nxt_s = 1'b1;
            instr_nxt_s = bus.imem_rdata;
            fpc_nxt_s   = addr_s;
        end else if (valid_r && !stall) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            pc_r       <= {RESET_PC[31:2], 2'b00};
            req_addr_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
            instr_r    <= 32'h0000_0000;
            fpc_r      <= 32'h0000_0000;
            misalign_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            req_addr_r <= req_addr_nxt_s;
            valid_r    <= valid_nxt_s;
            instr_r    <= instr_nxt_s;
            fpc_r      <= fpc_nxt_s;
            misalign_r <= misalign_nxt_s;
        end
    end

    // Request is forced low while reset is held so an abandoned fetch vanishes at once
    assign bus.imem_req  = rst_n && req_s;
    assign bus.imem_addr = addr_s;
    assign if_valid      = valid_r;
    assign if_instr      = instr_r;
    assign if_pc         = fpc_r;
    assign misalign_err  = misalign_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboarded bench for pc_fetch: a memory model with programmable wait states,
// directed scenarios, then randomized stall/redirect/wait-state traffic.
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PAT      = 32'hA5A5_A5A5;
    localparam int          WINDOW   = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misalign_err;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          n_consumed = 0;
    int          wait_n     = 0;
    int          mcnt       = 0;
    int          valid_cnt;
    logic [31:0] exp_q[$];

    logic        prev_pending;
    logic [31:0] prev_addr;
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic        exp_mis;
    logic [31:0] e_pc;

    logic        r_rd;
    logic [31:0] r_tgt;
    logic        r_st;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .bus          (bus.master),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ PAT;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected program-order stream starting at a fetch target
    task automatic refill(input logic [31:0] start);
        exp_q.delete();
        for (int k = 0; k < WINDOW; k++) exp_q.push_back(start + (32'(k) << 2));
    endtask

    task automatic step(input logic rd, input logic [31:0] tgt, input logic st);
        @(negedge clk);
        redirect    = rd;
        redirect_pc = tgt;
        stall       = st;
        #3;
        if (rd) refill({tgt[31:2], 2'b00});
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        refill(RESET_PC);
        #3;
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, RESET_PC);
    endtask

    task automatic step_until_valid();
        int k = 0;
        while (!if_valid && k < 20) begin
            step(1'b0, 32'd0, 1'b0);
            k++;
        end
    endtask

    task automatic expect_next_pc(input string name, input logic [31:0] pc);
        step_until_valid();
        chk({name, "_valid"}, 32'(if_valid), 32'd1);
        chk(name, if_pc, pc);
    endtask

    // Memory model: ack after wait_n extra cycles; ack held high with no wait states
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                bus.imem_ack = 1'b0;
                mcnt         = 0;
            end else if (wait_n == 0) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
                mcnt           = 0;
            end else if (bus.imem_req) begin
                if (mcnt >= wait_n) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(bus.imem_addr);
                    mcnt           = 0;
                end else begin
                    bus.imem_ack   = 1'b0;
                    bus.imem_rdata = $urandom;
                    mcnt++;
                end
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
                mcnt           = 0;
            end
        end
    end

    // Monitor: protocol rules every cycle, scoreboard pop on each hand-off to decode
    initial begin
        prev_pending = 1'b0;
        prev_hold    = 1'b0;
        exp_mis      = 1'b0;
        prev_addr    = 32'd0;
        prev_pc      = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_pending = 1'b0;
                prev_hold    = 1'b0;
                exp_mis      = 1'b0;
            end else begin
                if (prev_pending) begin
                    chk("req_held", 32'(bus.imem_req), 32'd1);
                    chk("addr_held", bus.imem_addr, prev_addr);
                end
                if (prev_hold) begin
                    chk("stall_hold_valid", 32'(if_valid), 32'd1);
                    chk("stall_hold_pc", if_pc, prev_pc);
                end
                chk("misalign_pulse", 32'(misalign_err), 32'(exp_mis));
                if (if_valid && stall) chk("stall_no_req", 32'(bus.imem_req), 32'd0);
                if (if_valid && !stall) begin
                    n_consumed++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scoreboard_empty: actual pc %h required none", if_pc);
                    end else begin
                        e_pc = exp_q.pop_front();
                        chk("sb_pc", if_pc, e_pc);
                        chk("sb_instr", if_instr, mem_word(e_pc));
                    end
                end
                prev_pending = bus.imem_req && !bus.imem_ack;
                prev_addr    = bus.imem_addr;
                prev_hold    = if_valid && stall && !redirect;
                prev_pc      = if_pc;
                exp_mis      = redirect && (redirect_pc[1:0] != 2'b00);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        stall       = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        repeat (2) @(negedge clk);
        release_reset();

        // Zero-wait sequential fetch, then stall with pc 8 in the slot
        step(1'b0, 32'd0, 1'b0);
        chk("seq0_valid", 32'(if_valid), 32'd1);
        chk("seq0_pc", if_pc, 32'd0);
        chk("seq0_instr", if_instr, 32'hA5A5_A5A5);
        step(1'b0, 32'd0, 1'b0);
        chk("seq1_pc", if_pc, 32'd4);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'd0, 1'b1);
            chk("stall_pc", if_pc, 32'd8);
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
        end
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("after_stall_pc", if_pc, 32'd12);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'd0, 1'b0);
            chk("throughput", 32'(if_valid), 32'd1);
        end

        // Redirect with zero-wait memory
        step(1'b1, 32'h0040_0100, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("redir_flush", 32'(if_valid), 32'd0);
        chk("redir_addr", bus.imem_addr, 32'h0040_0100);
        step(1'b0, 32'd0, 1'b0);
        chk("redir_valid", 32'(if_valid), 32'd1);
        chk("redir_pc", if_pc, 32'h0040_0100);
        chk("redir_instr", if_instr, 32'h0040_0100 ^ PAT);

        // Misaligned target and address wrap
        step(1'b1, 32'h0000_1003, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("mis_pulse", 32'(misalign_err), 32'd1);
        chk("mis_addr", bus.imem_addr, 32'h0000_1000);
        step(1'b0, 32'd0, 1'b0);
        chk("mis_clear", 32'(misalign_err), 32'd0);
        chk("mis_pc", if_pc, 32'h0000_1000);
        step(1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("wrap_top", if_pc, 32'hFFFF_FFFC);
        step(1'b0, 32'd0, 1'b0);
        chk("wrap_zero", if_pc, 32'd0);

        // Three wait states: one instruction per four cycles
        wait_n    = 3;
        valid_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 32'd0, 1'b0);
            if (if_valid) valid_cnt++;
        end
        chk("wait_rate", 32'(valid_cnt), 32'd10);

        // Redirect while a fetch is outstanding: late data must be discarded
        wait_n = 2;
        step(1'b0, 32'd0, 1'b0);
        step_until_valid();
        step(1'b1, 32'h0000_2000, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("kill_req", 32'(bus.imem_req), 32'd1);
        expect_next_pc("kill_target", 32'h0000_2000);

        // Asynchronous reset with a fetch outstanding
        wait_n = 3;
        step(1'b0, 32'd0, 1'b0);
        step_until_valid();
        step(1'b0, 32'd0, 1'b0);
        chk("pre_reset_req", 32'(bus.imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_req", 32'(bus.imem_req), 32'd0);
        chk("async_valid", 32'(if_valid), 32'd0);
        chk("async_pc", if_pc, 32'd0);
        repeat (2) @(negedge clk);
        release_reset();
        expect_next_pc("refetch_reset_pc", RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) wait_n = $urandom_range(0, 3);
            r_rd  = ($urandom_range(0, 9) == 0);
            r_tgt = $urandom;
            if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
            r_st  = ($urandom_range(0, 2) == 0);
            step(r_rd, r_tgt, r_st);
        end
        chk("deliveries", 32'(n_consumed >= 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage holding the program counter. It issues word fetches to instruction memory over a req/ack handshake and presents the fetched instruction and its PC to decode. It takes control-transfer targets (the jump/branch/jr/jal target select output) as a redirect. Its `if_pc` output is the PC that the target-select logic adds 4 to.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `redirect` in 1: a taken jump/branch/jr/jal this cycle.
- `redirect_pc` in 32: target from the next-PC select logic; valid when `redirect`=1.
- `stall` in 1: decode cannot accept; hold `if_*` outputs.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: word address of the fetch.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word; sampled only when `imem_ack`=1.
- `if_valid` out 1: `if_instr`/`if_pc` hold a live instruction.
- `if_instr` out 32: fetched instruction.
- `if_pc` out 32: address of `if_instr`.
- `misalign_err` out 1: one-cycle pulse when a redirect target had bits [1:0] != 0.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `req_addr`: address of the outstanding fetch.
  - `if_valid`, `if_instr`, `if_pc`, `misalign_err`.
  - 2-bit state.
- States:
  - RUN: nothing outstanding.
  - WAIT: fetch outstanding, result wanted.
  - KILL: fetch outstanding, result to be discarded.
- `imem_addr` = `pc` in RUN; `req_addr` in WAIT/KILL.
- `imem_req` = 1 in WAIT/KILL.
- In RUN, `imem_req` = 1 only when `redirect`=0 and the output slot is free or draining, i.e. !(`if_valid` && `stall`).
- Consume rule: at any edge with `if_valid`=1 and `stall`=0, decode takes the instruction. `if_valid` goes to 0 unless a new capture happens at the same edge.
- Capture: `if_instr`<=`imem_rdata`, `if_pc`<=fetched address, `if_valid`<=1, `pc`<=fetched address + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- RUN transitions:
  - `redirect`: `pc`<=`redirect_pc`, `if_valid`<=0, no request issued; an ack without a request is ignored; stay RUN.
  - Request issued with `imem_ack`=1: capture; stay RUN.
  - Request issued with `imem_ack`=0: `req_addr`<=`pc`; go to WAIT.
  - No request: hold everything.
- WAIT transitions:
  - `imem_ack` and no `redirect`: capture; go to RUN.
  - `redirect` and `imem_ack`: load `pc`, flush `if_valid`, drop the data; go to RUN.
  - `redirect` without `imem_ack`: load `pc`, flush; go to KILL.
- KILL transitions:
  - `imem_ack`: drop the data; go to RUN.
  - `redirect` in KILL: reload `pc` again.
- Redirect has priority over capture and over stall. A flush clears `if_valid` even when `stall`=1.
- Misaligned target: `pc`<={`redirect_pc`[31:2],2'b00}, and `misalign_err`<=1 for exactly one cycle.
- An outstanding request is never withdrawn: `imem_req` and `imem_addr` stay stable from first assertion until the cycle `imem_ack` is sampled high.

## Timing
- Reset values (immediate on `rst_n`=0, no clock required):
  - `pc`=`RESET_PC`, state=RUN.
  - `imem_req`=0 while `rst_n`=0.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `req_addr`=0, `misalign_err`=0.
- First cycle after `rst_n` rises: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Zero-wait memory (`imem_ack` tied 1): fetch latency is 1 cycle from request to `if_valid`, throughput is one instruction per cycle.
- N wait states: `if_valid` rises N+1 cycles after the request.
- Redirect with zero-wait memory: first fetch of the target is issued the cycle after `redirect`; the target instruction is valid 2 cycles after `redirect`.
- Reset asserted mid-WAIT/KILL: the outstanding request is abandoned. After reset the memory must not return a stale ack, so the bench keeps `imem_ack`=0 during reset.

## Test plan
- **Reset and sequential fetch:** reset with `RESET_PC`=0, ack tied 1, `imem_rdata`=addr^32'hA5A5_A5A5 -> `if_pc` = 0,4,8,12 on consecutive cycles, instructions match, `imem_req` low during reset.
- **Wait states:** ack delayed 3 cycles per request -> `imem_addr` stable while `imem_req` is high, `if_valid` high once per 4 cycles, no skipped or duplicated PC.
- **Stall:** `stall`=1 for 5 cycles while `if_valid`=1 at `if_pc`=8 -> `imem_req`=0 and outputs hold 8; after release, the next `if_pc`=12.
- **Redirect:**
  - Redirect to 32'h0040_0100 while ack tied 1 -> `if_valid`=0 next cycle, then `if_pc`=32'h0040_0100.
  - Redirect while in WAIT with ack 2 cycles later -> the late data is discarded (KILL) and the next captured `if_pc` is the target.
- **Misaligned and wrap:**
  - Redirect to 32'h0000_1003 -> `misalign_err` pulses one cycle and the fetch address is 32'h0000_1000.
  - Redirect to 32'hFFFF_FFFC -> the following `if_pc` is 0.
- **Async reset mid-WAIT:** `rst_n` dropped between clock edges -> `imem_req`=0 and `if_valid`=0 immediately; after release, refetch from `RESET_PC`.
